// File: rtl/ps2_device_bridge_if.sv
// Byte-stream, status and PS/2 line bundle between the IO controller side and
// the multi-channel PS/2 device bridge.
interface ps2_device_bridge_if #(
  parameter int CHANNELS = 2
);
  logic [CHANNELS-1:0]   wr_en;
  logic [7:0]            wr_data;
  logic [CHANNELS-1:0]   ovf_clr;
  logic [CHANNELS-1:0]   fifo_full;
  logic [CHANNELS-1:0]   overflow;
  logic [CHANNELS-1:0]   ps2_clk_out;
  logic [CHANNELS-1:0]   ps2_data_out;
  logic [CHANNELS-1:0]   ps2_clk_in;
  logic [CHANNELS-1:0]   ps2_data_in;
  logic [8*CHANNELS-1:0] rx_data;
  logic [CHANNELS-1:0]   rx_valid;
  logic [CHANNELS-1:0]   rx_err;

  modport master (
    output wr_en, wr_data, ovf_clr, ps2_clk_in, ps2_data_in,
    input  fifo_full, overflow, ps2_clk_out, ps2_data_out, rx_data, rx_valid, rx_err
  );

  modport slave (
    input  wr_en, wr_data, ovf_clr, ps2_clk_in, ps2_data_in,
    output fifo_full, overflow, ps2_clk_out, ps2_data_out, rx_data, rx_valid, rx_err
  );
endinterface

// File: rtl/ps2_device_bridge.sv
// Multi-channel PS/2 device emulator: per-channel TX FIFO and transmitter,
// host->device receiver with optional 0xFA acknowledge, inhibit abort/retry.
module ps2_device_bridge #(
  parameter int CHANNELS  = 2,
  parameter int FIFO_BITS = 4,
  parameter int CLK_DIV   = 1000,
  parameter int AUTO_ACK  = 1
) (
  input logic                clk_sys,
  input logic                reset,
  ps2_device_bridge_if.slave bus
);

  localparam int DEPTH = 2 ** FIFO_BITS;
  localparam int CW    = $clog2(CLK_DIV);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX,
    S_RTS_WAIT,
    S_RX,
    S_ACK
  } state_t;

  logic [CW-1:0] r_tick_cnt;
  logic          w_tick;

  assign w_tick = (r_tick_cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic             w_clk_in;
    logic             w_dat_in;
    logic             w_wr;

    logic [7:0]       r_mem [DEPTH];
    logic [FIFO_BITS:0] r_wptr;
    logic [FIFO_BITS:0] r_rptr;
    logic             w_empty;
    logic             w_full;
    logic             w_push_req;
    logic             w_push;
    logic             w_drop;
    logic [7:0]       w_push_data;
    logic [7:0]       w_head;
    logic [10:0]      w_head_frame;
    logic             r_ovf;
    logic             r_ack_pend;

    state_t           r_state, w_state_nxt;
    logic [3:0]       r_bit, w_bit_nxt;
    logic             r_clk_o, w_clk_o_nxt;
    logic             r_dat_o, w_dat_o_nxt;
    logic [9:0]       r_frame, w_frame_nxt;
    logic [8:0]       r_rx_sr, w_rx_sr_nxt;
    logic [7:0]       r_rx_data, w_rx_data_nxt;
    logic             r_rx_valid, w_rx_valid_nxt;
    logic             r_rx_err, w_rx_err_nxt;
    logic             w_rx_good;
    logic             w_pop;
    logic             w_ack_set;

    assign w_clk_in = bus.ps2_clk_in[ch];
    assign w_dat_in = bus.ps2_data_in[ch];
    assign w_wr     = bus.wr_en[ch];

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[FIFO_BITS] != r_rptr[FIFO_BITS]) &&
                     (r_wptr[FIFO_BITS-1:0] == r_rptr[FIFO_BITS-1:0]);

    // A pending acknowledge yields to a same-cycle host write and retries next cycle.
    assign w_push_req  = w_wr | r_ack_pend;
    assign w_push_data = w_wr ? bus.wr_data : 8'hFA;
    assign w_push      = w_push_req & ~w_full;
    assign w_drop      = w_push_req & w_full;

    assign w_head       = r_mem[r_rptr[FIFO_BITS-1:0]];
    assign w_head_frame = {1'b1, ~^w_head, w_head, 1'b0};
    assign w_rx_good    = (^r_rx_sr) & w_dat_in;

    always_ff @(posedge clk_sys) begin
      if (w_push) begin
        r_mem[r_wptr[FIFO_BITS-1:0]] <= w_push_data;
      end
    end

    always_ff @(posedge clk_sys) begin
      if (reset) begin
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_ovf      <= 1'b0;
        r_ack_pend <= 1'b0;
      end else begin
        if (w_push) begin
          r_wptr <= r_wptr + 1'b1;
        end
        if (w_pop) begin
          r_rptr <= r_rptr + 1'b1;
        end
        if (w_drop) begin
          r_ovf <= 1'b1;
        end else if (bus.ovf_clr[ch]) begin
          r_ovf <= 1'b0;
        end
        r_ack_pend <= w_ack_set | (r_ack_pend & w_wr);
      end
    end

    always_ff @(posedge clk_sys) begin
      if (reset) begin
        r_state    <= S_IDLE;
        r_bit      <= '0;
        r_clk_o    <= 1'b1;
        r_dat_o    <= 1'b1;
        r_frame    <= '1;
        r_rx_sr    <= '0;
        r_rx_data  <= '0;
        r_rx_valid <= 1'b0;
        r_rx_err   <= 1'b0;
      end else begin
        r_state    <= w_state_nxt;
        r_bit      <= w_bit_nxt;
        r_clk_o    <= w_clk_o_nxt;
        r_dat_o    <= w_dat_o_nxt;
        r_frame    <= w_frame_nxt;
        r_rx_sr    <= w_rx_sr_nxt;
        r_rx_data  <= w_rx_data_nxt;
        r_rx_valid <= w_rx_valid_nxt;
        r_rx_err   <= w_rx_err_nxt;
      end
    end

    always_comb begin
      w_state_nxt    = r_state;
      w_bit_nxt      = r_bit;
      w_clk_o_nxt    = r_clk_o;
      w_dat_o_nxt    = r_dat_o;
      w_frame_nxt    = r_frame;
      w_rx_sr_nxt    = r_rx_sr;
      w_rx_data_nxt  = r_rx_data;
      w_rx_valid_nxt = 1'b0;
      w_rx_err_nxt   = 1'b0;
      w_pop          = 1'b0;
      w_ack_set      = 1'b0;
      if (w_tick) begin
        case (r_state)
          S_IDLE: begin
            if (!w_empty && w_clk_in && w_dat_in) begin
              w_state_nxt = S_TX;
              w_bit_nxt   = '0;
              w_frame_nxt = w_head_frame[10:1];
              w_clk_o_nxt = 1'b1;
              w_dat_o_nxt = w_head_frame[0];
            end else if (!w_clk_in && !w_dat_in) begin
              w_state_nxt = S_RTS_WAIT;
            end
          end
          S_TX: begin
            if (r_clk_o) begin
              // Inhibit in the high phase aborts; during the stop bit the byte counts as sent.
              if (!w_clk_in) begin
                w_state_nxt = S_IDLE;
                w_clk_o_nxt = 1'b1;
                w_dat_o_nxt = 1'b1;
                w_pop       = (r_bit == 4'd10);
              end else begin
                w_clk_o_nxt = 1'b0;
              end
            end else if (r_bit == 4'd10) begin
              w_state_nxt = S_IDLE;
              w_clk_o_nxt = 1'b1;
              w_dat_o_nxt = 1'b1;
              w_pop       = 1'b1;
            end else begin
              w_bit_nxt   = r_bit + 4'd1;
              w_clk_o_nxt = 1'b1;
              w_dat_o_nxt = r_frame[0];
              w_frame_nxt = {1'b1, r_frame[9:1]};
            end
          end
          S_RTS_WAIT: begin
            if (w_clk_in) begin
              w_state_nxt = w_dat_in ? S_IDLE : S_RX;
              w_bit_nxt   = '0;
            end
          end
          S_RX: begin
            if (r_clk_o) begin
              w_clk_o_nxt = 1'b0;
            end else begin
              w_clk_o_nxt = 1'b1;
              if (r_bit == 4'd9) begin
                w_state_nxt = S_ACK;
                w_bit_nxt   = '0;
                if (w_rx_good) begin
                  w_rx_data_nxt  = r_rx_sr[7:0];
                  w_rx_valid_nxt = 1'b1;
                  w_ack_set      = (AUTO_ACK != 0);
                end else begin
                  w_rx_err_nxt = 1'b1;
                end
              end else begin
                w_rx_sr_nxt = {w_dat_in, r_rx_sr[8:1]};
                w_bit_nxt   = r_bit + 4'd1;
              end
            end
          end
          S_ACK: begin
            if (r_clk_o && r_dat_o) begin
              w_clk_o_nxt = 1'b0;
              w_dat_o_nxt = 1'b0;
            end else if (!r_clk_o) begin
              w_clk_o_nxt = 1'b1;
            end else begin
              w_dat_o_nxt = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end
          default: begin
            w_state_nxt = S_IDLE;
            w_clk_o_nxt = 1'b1;
            w_dat_o_nxt = 1'b1;
          end
        endcase
      end
    end

    assign bus.fifo_full[ch]        = w_full;
    assign bus.overflow[ch]         = r_ovf;
    assign bus.ps2_clk_out[ch]      = r_clk_o;
    assign bus.ps2_data_out[ch]     = r_dat_o;
    assign bus.rx_data[8*ch +: 8]   = r_rx_data;
    assign bus.rx_valid[ch]         = r_rx_valid;
    assign bus.rx_err[ch]           = r_rx_err;
  end

endmodule

// File: tb/tb_ps2_device_bridge.sv
// Bench for ps2_device_bridge: table-driven transmit vectors with a frame
// scoreboard, plus host-send, inhibit, overflow and reset sequences.
module tb_ps2_device_bridge;
  localparam int CH  = 2;
  localparam int FB  = 4;
  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_device_bridge_if #(.CHANNELS(CH)) bif ();

  ps2_device_bridge #(
    .CHANNELS (CH),
    .FIFO_BITS(FB),
    .CLK_DIV  (DIV),
    .AUTO_ACK (1)
  ) dut (
    .clk_sys(clk),
    .reset  (rst),
    .bus    (bif.slave)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         ch;
    logic [7:0] data;
    logic       par;
  } vec_t;
  vec_t vecs[7];

  logic [10:0] q0[$];
  logic [10:0] q1[$];
  logic [1:0]  host_active = '0;
  logic [1:0]  prev_clk = '1;
  int          nbits[2] = '{0, 0};
  logic [10:0] shreg[2];
  logic [10:0] last_frame[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] frm(input logic [7:0] d, input logic p);
    return {1'b1, p, d, 1'b0};
  endfunction

  function automatic logic oddpar(input logic [7:0] d);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(d[i]);
    return (n % 2 == 0);
  endfunction

  task automatic expect_frame(input int ch, input logic [10:0] f);
    if (ch == 0) q0.push_back(f);
    else         q1.push_back(f);
  endtask

  task automatic frame_done(input int ch, input logic [10:0] f);
    logic [10:0] e;
    logic        have;
    have = 1'b0;
    e    = '0;
    if (ch == 0 && q0.size() > 0) begin have = 1'b1; e = q0.pop_front(); end
    if (ch == 1 && q1.size() > 0) begin have = 1'b1; e = q1.pop_front(); end
    if (!have) begin
      total++;
      bad++;
      $display("FAIL unexpected_frame ch%0d: got %03h want none", ch, f);
    end else begin
      check($sformatf("frame_ch%0d", ch), 32'(f), 32'(e));
    end
  endtask

  // Host-side receiver: data is read on each falling edge of the device clock.
  always @(negedge clk) begin
    for (int c = 0; c < CH; c++) begin
      if (rst || !bif.ps2_clk_in[c] || host_active[c]) begin
        nbits[c] = 0;
      end else if (prev_clk[c] && !bif.ps2_clk_out[c]) begin
        shreg[c][nbits[c]] = bif.ps2_data_out[c];
        nbits[c]++;
        if (nbits[c] == 11) begin
          last_frame[c] = shreg[c];
          frame_done(c, shreg[c]);
          nbits[c] = 0;
        end
      end
      prev_clk[c] = bif.ps2_clk_out[c];
    end
  end

  task automatic tick_wait(input int n);
    repeat (n * DIV) @(negedge clk);
  endtask

  task automatic wr(input int ch, input logic [7:0] d);
    bif.wr_en     = '0;
    bif.wr_en[ch] = 1'b1;
    bif.wr_data   = d;
    @(negedge clk);
    bif.wr_en = '0;
  endtask

  task automatic wait_queues(input int budget, input string name);
    int n = 0;
    while ((q0.size() + q1.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(q0.size() + q1.size()), 0);
  endtask

  task automatic wait_clk_fall(input int ch, input int budget, output logic ok);
    logic p;
    int   n = 0;
    p  = bif.ps2_clk_out[ch];
    ok = 1'b0;
    while (!ok && n < budget) begin
      @(negedge clk);
      n++;
      if (p && !bif.ps2_clk_out[ch]) ok = 1'b1;
      p = bif.ps2_clk_out[ch];
    end
  endtask

  task automatic host_send(input int ch, input logic [7:0] d, input logic par,
                           input logic exp_good, input logic collide, input logic [7:0] exp_rx);
    logic [9:0] bits;
    logic       ok, all_ok, seen_v, seen_e;
    int         n;
    bits = {1'b1, par, d};
    host_active[ch]     = 1'b1;
    bif.ps2_data_in[ch] = 1'b0;
    bif.ps2_clk_in[ch]  = 1'b0;
    tick_wait(3);
    bif.ps2_clk_in[ch] = 1'b1;
    all_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_clk_fall(ch, 6 * DIV, ok);
      if (!ok) begin all_ok = 1'b0; break; end
      bif.ps2_data_in[ch] = bits[i];
    end
    check($sformatf("rx_clock_pulses_ch%0d", ch), 32'(all_ok), 1);
    n = 0; seen_v = 1'b0; seen_e = 1'b0;
    while (!seen_v && !seen_e && n < 4 * DIV) begin
      @(negedge clk);
      seen_v = bif.rx_valid[ch];
      seen_e = bif.rx_err[ch];
      n++;
    end
    check($sformatf("rx_valid_ch%0d", ch), 32'(seen_v), 32'(exp_good));
    check($sformatf("rx_err_ch%0d", ch), 32'(seen_e), 32'(!exp_good));
    if (collide && seen_v) begin
      bif.wr_en[ch] = 1'b1;
      bif.wr_data   = 8'h3C;
      expect_frame(ch, frm(8'h3C, 1'b1));
    end
    if (exp_good) expect_frame(ch, frm(8'hFA, 1'b1));
    @(negedge clk);
    bif.wr_en = '0;
    check($sformatf("rx_pulse_len_ch%0d", ch), 32'({bif.rx_valid[ch], bif.rx_err[ch]}), 0);
    check($sformatf("rx_data_ch%0d", ch), 32'(bif.rx_data[8*ch +: 8]), 32'(exp_rx));
    wait_clk_fall(ch, 3 * DIV, ok);
    check($sformatf("ack_low_ch%0d", ch), 32'({ok, bif.ps2_data_out[ch]}), 2'b10);
    n = 0;
    while (!bif.ps2_data_out[ch] && n < 4 * DIV) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("ack_release_ch%0d", ch),
          32'({bif.ps2_clk_out[ch], bif.ps2_data_out[ch]}), 2'b11);
    bif.ps2_data_in[ch] = 1'b1;
    host_active[ch]     = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       ok;
    int         n;
    bif.wr_en       = '0;
    bif.wr_data     = '0;
    bif.ovf_clr     = '0;
    bif.ps2_clk_in  = '1;
    bif.ps2_data_in = '1;

    vecs[0] = '{0, 8'h1C, 1'b0};
    vecs[1] = '{1, 8'h00, 1'b1};
    vecs[2] = '{0, 8'hFF, 1'b1};
    vecs[3] = '{1, 8'h5A, 1'b1};
    vecs[4] = '{0, 8'h01, 1'b0};
    vecs[5] = '{1, 8'h80, 1'b0};
    vecs[6] = '{0, 8'h37, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_fifo_full", 32'(bif.fifo_full), 0);
    check("rst_overflow", 32'(bif.overflow), 0);
    check("rst_clk_out", 32'(bif.ps2_clk_out), 2'b11);
    check("rst_data_out", 32'(bif.ps2_data_out), 2'b11);
    check("rst_rx_flags", 32'({bif.rx_valid, bif.rx_err}), 0);
    check("rst_rx_data", 32'(bif.rx_data), 0);
    rst = 1'b0;

    // Single 0x1C frame: bits 0,0,0,1,1,1,0,0,0,0,1
    expect_frame(0, frm(8'h1C, 1'b0));
    wr(0, 8'h1C);
    wait_queues(40 * DIV, "drain_1c");
    check("frame_1c_bits", 32'(last_frame[0]), 11'b100_0011_1000);

    foreach (vecs[i]) begin
      expect_frame(vecs[i].ch, frm(vecs[i].data, vecs[i].par));
      wr(vecs[i].ch, vecs[i].data);
    end
    wait_queues(150 * DIV, "drain_table");

    // Fill ch1 while inhibited
    bif.ps2_clk_in[1] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      d = 8'h40 + 8'(i);
      expect_frame(1, frm(d, oddpar(d)));
      wr(1, d);
      if (i == 14) check("full_after_15", 32'(bif.fifo_full), 0);
    end
    check("full_after_16", 32'(bif.fifo_full), 2'b10);
    check("no_ovf_at_16", 32'(bif.overflow), 0);
    wr(1, 8'hEE);
    check("ovf_after_17", 32'(bif.overflow), 2'b10);
    bif.ovf_clr = 2'b10;
    wr(1, 8'hEF);
    bif.ovf_clr = '0;
    check("ovf_set_beats_clr", 32'(bif.overflow), 2'b10);
    bif.ovf_clr = 2'b10;
    @(negedge clk);
    bif.ovf_clr = '0;
    check("ovf_cleared", 32'(bif.overflow), 0);
    bif.ps2_clk_in[1] = 1'b1;
    wait_queues(16 * 26 * DIV, "drain_ch1_16");
    check("ch1_not_full", 32'(bif.fifo_full), 0);

    // Inhibit during bit 4 of 0xAA
    expect_frame(0, frm(8'hAA, 1'b1));
    wr(0, 8'hAA);
    n = 0;
    while (nbits[0] != 4 && n < 40 * DIV) begin @(negedge clk); n++; end
    check("reach_bit4", 32'(nbits[0]), 4);
    n = 0;
    while (!bif.ps2_clk_out[0] && n < 2 * DIV) begin @(negedge clk); n++; end
    bif.ps2_clk_in[0] = 1'b0;
    tick_wait(2);
    check("abort_lines", 32'({bif.ps2_clk_out[0], bif.ps2_data_out[0]}), 2'b11);
    check("abort_no_frame", 32'(q0.size()), 1);
    tick_wait(4);
    check("inhibit_hold_lines", 32'({bif.ps2_clk_out[0], bif.ps2_data_out[0]}), 2'b11);
    bif.ps2_clk_in[0] = 1'b1;
    wait_queues(30 * DIV, "resend_aa");

    // Host->device frames
    host_send(1, 8'hED, 1'b0, 1'b0, 1'b0, 8'h00);
    host_send(0, 8'hED, 1'b1, 1'b1, 1'b0, 8'hED);
    wait_queues(30 * DIV, "ack_fa_ch0");
    host_send(0, 8'h12, 1'b0, 1'b0, 1'b0, 8'hED);
    host_send(1, 8'hF3, 1'b1, 1'b1, 1'b1, 8'hF3);
    wait_queues(60 * DIV, "collide_then_fa_ch1");
    tick_wait(40);
    check("idle_lines", 32'({bif.ps2_clk_out, bif.ps2_data_out}), 4'hF);

    // Reset while both channels transmit
    bif.ps2_clk_in[1] = 1'b0;
    for (int i = 0; i < 17; i++) wr(1, 8'(8'h60 + i));
    wr(0, 8'h11);
    wr(0, 8'h22);
    check("pre_rst_full", 32'(bif.fifo_full), 2'b10);
    check("pre_rst_ovf", 32'(bif.overflow), 2'b10);
    bif.ps2_clk_in[1] = 1'b1;
    n = 0;
    while (!(nbits[0] >= 3 && nbits[1] >= 3) && n < 60 * DIV) begin @(negedge clk); n++; end
    ok = (nbits[0] >= 3 && nbits[1] >= 3);
    check("both_mid_tx", 32'(ok), 1);
    q0.delete();
    q1.delete();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_clk_out", 32'(bif.ps2_clk_out), 2'b11);
    check("mid_rst_data_out", 32'(bif.ps2_data_out), 2'b11);
    check("mid_rst_full", 32'(bif.fifo_full), 0);
    check("mid_rst_ovf", 32'(bif.overflow), 0);
    check("mid_rst_rx_data", 32'(bif.rx_data), 0);
    tick_wait(40);
    check("post_rst_idle", 32'({bif.ps2_clk_out, bif.ps2_data_out}), 4'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
